// File: rtl/sdram_arb_pkg.sv
// Shared command codes, burst lengths and owner encoding for the SDRAM command arbiter.
package sdram_arb_pkg;
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR256 = 2'b01;
  localparam logic [1:0] CMD_RD32  = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  localparam int BURST_VID  = 16;
  localparam int BURST_LINE = 128;

  typedef enum logic [1:0] {NONE = 2'd0, VID = 2'd1, WB = 2'd2, FILL = 2'd3} owner_t;
endpackage

// File: rtl/sdram_cmd_arbiter_vid_addr_gen.sv
// Video frame pointer: advances per accepted video burst, wraps per frame, restart clears it.
module vid_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int          VID_WORDS = 3072,
  parameter logic [14:0] VID_BASE  = 15'h6ff8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        restart,
  output logic [17:0] addr
);
  logic [11:0] ptr;
  logic [14:0] word;

  // Upper pointer bits are inverted so the frame is laid out downward from the base.
  assign word = VID_BASE + {3'b000, ~ptr[11:2], ptr[1:0]};
  assign addr = {word, 3'b000};

  always_ff @(posedge clk) begin
    if (rst || restart)   ptr <= '0;
    else if (advance)     ptr <= (ptr == 12'(VID_WORDS - 1)) ? 12'd0 : ptr + 12'd1;
  end
endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Schedules video prefetch, cache write-back and cache fill bursts onto one SDRAM command port.
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int          VID_WORDS  = 3072,
  parameter logic [14:0] VID_BASE   = 15'h6ff8,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        vid_restart,
  input  logic        wb_req,
  input  logic [11:0] wb_line,
  input  logic        fill_req,
  input  logic [11:0] fill_line,
  output logic [1:0]  sys_cmd,
  output logic [17:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_write_data,
  output logic        cache_read_data,
  output logic [31:0] vq_data,
  output logic        vq_we,
  output logic [1:0]  owner
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam int         SW       = $clog2(STARVE_MAX + 1);

  logic [1:0]    state;
  owner_t        own;
  logic [6:0]    beat;
  logic [SW-1:0] starve;
  logic [15:0]   lo;
  logic [17:0]   vid_addr;
  logic          accept, cache_pend, vid_win, beat_stb, last_beat;

  assign accept     = (state == ST_ISSUE) && (sys_cmd != CMD_NOP) && (sys_cmd_ack == sys_cmd);
  assign cache_pend = wb_req | fill_req;
  assign vid_win    = vid_low && !(cache_pend && (starve >= SW'(STARVE_MAX)));
  assign beat_stb   = (state == ST_DATA) && ((own == WB) ? sys_wr_data_valid : sys_rd_data_valid);
  assign last_beat  = beat == ((own == VID) ? 7'(BURST_VID - 1) : 7'(BURST_LINE - 1));

  assign cache_write_data = sys_rd_data_valid && (own == FILL);
  assign cache_read_data  = sys_wr_data_valid && (own == WB);
  assign owner            = own;

  vid_addr_gen #(.VID_WORDS(VID_WORDS), .VID_BASE(VID_BASE)) u_vid (
    .clk     (clk),
    .rst     (rst),
    .advance (accept && (own == VID)),
    .restart (vid_restart),
    .addr    (vid_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      own      <= NONE;
      sys_cmd  <= CMD_NOP;
      sys_addr <= '0;
      beat     <= '0;
      starve   <= '0;
      lo       <= '0;
      vq_data  <= '0;
      vq_we    <= 1'b0;
    end else begin
      vq_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (vid_win) begin
            state    <= ST_ISSUE;
            own      <= VID;
            sys_cmd  <= CMD_RD32;
            sys_addr <= vid_addr;
            if (cache_pend) starve <= starve + 1'b1;
          end else if (wb_req) begin
            state    <= ST_ISSUE;
            own      <= WB;
            sys_cmd  <= CMD_WR256;
            sys_addr <= {wb_line, 6'b0};
            starve   <= '0;
          end else if (fill_req) begin
            state    <= ST_ISSUE;
            own      <= FILL;
            sys_cmd  <= CMD_RD256;
            sys_addr <= {fill_line, 6'b0};
            starve   <= '0;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            sys_cmd <= CMD_NOP;
            state   <= ST_DATA;
            beat    <= '0;
          end
        end
        ST_DATA: begin
          if (beat_stb) begin
            // Video beats pair up: low half first, the odd beat completes the word.
            if (own == VID) begin
              if (!beat[0]) lo <= sys_dout;
              else begin
                vq_data <= {sys_dout, lo};
                vq_we   <= 1'b1;
              end
            end
            if (last_beat) begin
              state <= ST_IDLE;
              own   <= NONE;
              beat  <= '0;
            end else begin
              beat <= beat + 7'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench: stimulus pushes expected commands/video words, a negedge monitor checks them.
module tb_sdram_cmd_arbiter;
  import sdram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_low = 1'b0, vid_restart = 1'b0, wb_req = 1'b0, fill_req = 1'b0;
  logic [11:0] wb_line = '0, fill_line = '0;
  logic [1:0]  sys_cmd, sys_cmd_ack = '0;
  logic [17:0] sys_addr;
  logic        sys_rd_data_valid = 1'b0, sys_wr_data_valid = 1'b0;
  logic [15:0] sys_dout = '0;
  logic        cache_write_data, cache_read_data, vq_we;
  logic [31:0] vq_data;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  sdram_cmd_arbiter dut (
    .clk(clk), .rst(rst), .vid_low(vid_low), .vid_restart(vid_restart),
    .wb_req(wb_req), .wb_line(wb_line), .fill_req(fill_req), .fill_line(fill_line),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_write_data(cache_write_data), .cache_read_data(cache_read_data),
    .vq_data(vq_data), .vq_we(vq_we), .owner(owner)
  );

  int tests = 0, fails = 0;
  int cwd_cnt = 0, crd_cnt = 0;
  int eptr = 0;
  logic [19:0] cmd_q[$];
  logic [31:0] vq_q[$];
  logic [1:0]  prev_cmd = 2'b00;
  logic [19:0] ecmd;
  logic [31:0] evq;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] vaddr(int p);
    logic [11:0] q;
    q = p[11:0];
    return {15'h6ff8 + {3'b000, ~q[11:2], q[1:0]}, 3'b000};
  endfunction

  task automatic push_vid(logic [17:0] a, logic [15:0] base);
    cmd_q.push_back({CMD_RD32, a});
    for (int i = 0; i < 8; i++)
      vq_q.push_back({16'(base + 16'(2*i+1)), 16'(base + 16'(2*i))});
    eptr = (eptr == 3071) ? 0 : eptr + 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Controller model: wait for a command, optionally show a wrong ack, ack, then stream beats.
  task automatic serve(int dly, logic [15:0] base, bit rs, bit bad);
    bit got;
    logic [1:0] c;
    int n;
    got = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (sys_cmd != 2'b00) got = 1;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL serve_timeout: got no command, required one within 64 cycles");
      return;
    end
    c = sys_cmd;
    tick();
    if (bad) begin
      sys_cmd_ack = c ^ 2'b11;
      tick();
      sys_cmd_ack = 2'b00;
      check("cmd_held_on_bad_ack", 32'(sys_cmd), 32'(c));
    end
    repeat (dly) tick();
    sys_cmd_ack = c; vid_restart = rs;
    tick();
    sys_cmd_ack = 2'b00; vid_restart = 1'b0;
    check("cmd_drop_after_ack", 32'(sys_cmd), 32'(CMD_NOP));
    n = (c == CMD_RD32) ? 16 : 128;
    for (int i = 0; i < n; i++) begin
      if (c == CMD_WR256) sys_wr_data_valid = 1'b1; else sys_rd_data_valid = 1'b1;
      sys_dout = base + 16'(i);
      tick();
    end
    sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sys_cmd != 2'b00 && prev_cmd == 2'b00) begin
      if (cmd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_cmd: got cmd %b addr %h, required none", sys_cmd, sys_addr);
      end else begin
        ecmd = cmd_q.pop_front();
        check("cmd", 32'(sys_cmd), 32'(ecmd[19:18]));
        check("addr", 32'(sys_addr), 32'(ecmd[17:0]));
      end
    end
    prev_cmd = sys_cmd;
    if (vq_we) begin
      if (vq_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_vq_we: got data %h, required no write", vq_data);
      end else begin
        evq = vq_q.pop_front();
        check("vq_data", vq_data, evq);
      end
    end
    if (cache_write_data) cwd_cnt++;
    if (cache_read_data)  crd_cnt++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0;
    logic [15:0] b;
    // Reset state, with valid strobes forced high to show the cache gating.
    sys_rd_data_valid = 1'b1; sys_wr_data_valid = 1'b1;
    repeat (3) tick();
    check("rst_sys_cmd", 32'(sys_cmd), 32'h0);
    check("rst_sys_addr", 32'(sys_addr), 32'h0);
    check("rst_owner", 32'(owner), 32'(NONE));
    check("rst_vq_we", 32'(vq_we), 32'h0);
    check("rst_vq_data", vq_data, 32'h0);
    check("rst_cache_wr", 32'(cache_write_data), 32'h0);
    check("rst_cache_rd", 32'(cache_read_data), 32'h0);
    sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single video burst, ack after 3 cycles.
    vid_low = 1'b1;
    push_vid(18'h3ffa0, 16'h0001);
    serve(3, 16'h0001, 0, 0);
    vid_low = 1'b0;
    repeat (3) tick();
    check("vq_drained_t1", 32'(vq_q.size()), 32'h0);

    // WB and FILL together: WB first, with one mismatched ack.
    wb_line = 12'h005; fill_line = 12'h0a3;
    wb_req = 1'b1; fill_req = 1'b1;
    cmd_q.push_back({CMD_WR256, 18'h00140});
    cmd_q.push_back({CMD_RD256, 18'h028c0});
    c0 = cwd_cnt; r0 = crd_cnt;
    serve(1, 16'h1000, 0, 1);
    wb_req = 1'b0;
    check("wb_read_beats", 32'(crd_cnt - r0), 32'd128);
    check("wb_no_fill_beats", 32'(cwd_cnt - c0), 32'd0);
    serve(0, 16'h2000, 0, 0);
    fill_req = 1'b0;
    check("fill_write_beats", 32'(cwd_cnt - c0), 32'd128);
    check("fill_no_wb_beats", 32'(crd_cnt - r0), 32'd128);

    // Starvation guard: 4 VID then 1 FILL, twice (pointer continues from 1).
    vid_low = 1'b1; fill_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b = 16'(16'h3000 + k*32);
      if (k % 5 == 4) cmd_q.push_back({CMD_RD256, 18'h028c0});
      else if (k == 0) push_vid(18'h3ffa8, b);
      else push_vid(vaddr(eptr), b);
      serve(0, b, 0, 0);
    end
    vid_low = 1'b0; fill_req = 1'b0;
    tick();

    // Restart while idle, then restart coinciding with the acceptance at pointer 100.
    vid_restart = 1'b1; tick(); vid_restart = 1'b0;
    eptr = 0;
    vid_low = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      b = 16'(k*32);
      if (k == 100) push_vid(18'h3fc80, b); else push_vid(vaddr(eptr), b);
      serve(0, b, k == 100, 0);
    end
    eptr = 0;
    // Full frame: pointer 0..3071, then wrap back to 0.
    for (int k = 0; k < 3073; k++) begin
      b = 16'(k*32);
      if (eptr == 3071) push_vid(18'h39fd8, b);
      else if (k == 3072) push_vid(18'h3ffa0, b);
      else push_vid(vaddr(eptr), b);
      serve(0, b, 0, 0);
    end
    vid_low = 1'b0;
    repeat (3) tick();

    // Reset during beat 40 of a fill.
    fill_line = 12'h011; fill_req = 1'b1;
    cmd_q.push_back({CMD_RD256, 18'h00440});
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 64 && !got; i++) begin
        @(negedge clk);
        if (sys_cmd != 2'b00) got = 1;
      end
      if (!got) begin
        tests++; fails++;
        $display("FAIL rst_fill_timeout: got no command, required fill");
      end
    end
    tick();
    sys_cmd_ack = CMD_RD256; tick(); sys_cmd_ack = 2'b00;
    fill_req = 1'b0;
    c0 = cwd_cnt;
    sys_rd_data_valid = 1'b1;
    repeat (40) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_owner", 32'(owner), 32'(NONE));
    repeat (87) tick();
    sys_rd_data_valid = 1'b0;
    tick();
    check("rst_mid_cache_beats", 32'(cwd_cnt - c0), 32'd41);
    check("rst_mid_sys_cmd", 32'(sys_cmd), 32'h0);
    eptr = 0;
    vid_low = 1'b1;
    push_vid(18'h3ffa0, 16'h5000);
    serve(2, 16'h5000, 0, 0);
    vid_low = 1'b0;
    repeat (4) tick();

    check("cmd_queue_empty", 32'(cmd_q.size()), 32'h0);
    check("vq_queue_empty", 32'(vq_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
